// File: rtl/uart_tx_pkg.sv
// Shared UART framing definitions: FSM state codes, legal parameter ranges, parity helper.
// Intended for reuse by the matching receiver.
package uart_tx_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WAIT   = 3'd1;
   localparam logic [2:0] ST_START  = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_PARITY = 3'd4;
   localparam logic [2:0] ST_STOP   = 3'd5;

   localparam int unsigned MIN_DATA_BITS = 5;
   localparam int unsigned MAX_DATA_BITS = 8;
   localparam int unsigned MIN_STOP_BITS = 1;
   localparam int unsigned MAX_STOP_BITS = 2;

   // Narrow words are zero-extended by the caller, which leaves the XOR unchanged.
   function automatic logic calc_parity(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_baud_tick_detect.sv
// Registers the baud square wave and emits a one-clock pulse on each rising edge.
module uart_tx_baud_tick_detect (
   input  logic clk,
   input  logic arst_n,
   input  logic baud_i,
   output logic tick_o
);

   logic baud_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         baud_q <= 1'b0;
      end else begin
         baud_q <= baud_i;
      end
   end

   assign tick_o = baud_i & ~baud_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, framed LSB-first serial out, one bit per baud tick.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic                 baud_in,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
      $error("uart_tx: DATA_BITS must be in 5..8");
   end
   if (STOP_BITS < MIN_STOP_BITS || STOP_BITS > MAX_STOP_BITS) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   logic                 baud_tick;
   logic [2:0]           state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   uart_tx_baud_tick_detect u_tick (
      .clk    (clk),
      .arst_n (arst_n),
      .baud_i (baud_in),
      .tick_o (baud_tick)
   );

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      par_d      = par_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      // A tick coinciding with the handshake is deliberately ignored in IDLE.
      case (state_q)
         ST_IDLE: begin
            if (tx_valid) begin
               shreg_d = tx_data;
               par_d   = calc_parity(8'(tx_data), 1'(PARITY_ODD));
               busy_d  = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (baud_tick) state_d = ST_START;
         end
         ST_START: begin
            if (baud_tick) begin
               bit_cnt_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (baud_tick) begin
               shreg_d = shreg_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  stop_cnt_d = 1'b0;
                  state_d    = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (baud_tick) begin
               stop_cnt_d = 1'b0;
               state_d    = ST_STOP;
            end
         end
         ST_STOP: begin
            if (baud_tick) begin
               if (stop_cnt_q == LAST_STOP) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Line level follows the state being entered so tx is a clean register output.
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shreg_d[0];
         ST_PARITY: tx_d = par_d;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         par_q      <= 1'b0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         par_q      <= par_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx_ready = (state_q == ST_IDLE);
   assign tx       = tx_q;
   assign tx_busy  = busy_q;
   assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three framing variants driven from a shortened baud square wave.
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int Half = 8;         // baud half-period in clks
   localparam int Bit  = 2 * Half;  // bit period in clks

   logic       clk      = 1'b0;
   logic       arst_n   = 1'b0;
   logic       baud_in  = 1'b0;
   logic [7:0] tx_data  = '0;
   logic [2:0] tx_valid = '0;
   logic [2:0] tx_ready, tx, tx_busy, tx_done;
   int         baud_cnt = 0;
   int         checks   = 0;
   int         errors   = 0;

   always #10 clk = ~clk;

   always @(posedge clk) begin
      if (baud_cnt == Half - 1) begin
         baud_cnt <= 0;
         baud_in  <= ~baud_in;
      end else begin
         baud_cnt <= baud_cnt + 1;
      end
   end

   uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .arst_n(arst_n), .baud_in(baud_in), .tx_data(tx_data),
      .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx(tx[0]),
      .tx_busy(tx_busy[0]), .tx_done(tx_done[0])
   );

   uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_8e2 (
      .clk(clk), .arst_n(arst_n), .baud_in(baud_in), .tx_data(tx_data),
      .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx(tx[1]),
      .tx_busy(tx_busy[1]), .tx_done(tx_done[1])
   );

   uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
      .clk(clk), .arst_n(arst_n), .baud_in(baud_in), .tx_data(tx_data),
      .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .tx(tx[2]),
      .tx_busy(tx_busy[2]), .tx_done(tx_done[2])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Park on the negedge where the DUT sees a fresh baud rising edge.
   task automatic sync_tick();
      do @(negedge clk); while (!(baud_in === 1'b1 && baud_cnt == 0));
   endtask

   task automatic send(input int sel, input logic [7:0] data);
      tx_data       = data;
      tx_valid[sel] = 1'b1;
      @(negedge clk);
      chk($sformatf("hs_busy%0d", sel), 32'(tx_busy[sel]), 1);
      chk($sformatf("hs_ready%0d", sel), 32'(tx_ready[sel]), 0);
      tx_valid[sel] = 1'b0;
   endtask

   // bits[i] is the i-th serial bit (start first); gap_exp < 0 skips the start-latency check.
   task automatic check_frame(input int sel, input string tag, input logic [15:0] bits,
                              input int n, input int gap_exp);
      int wait_cnt = 0;
      while (tx[sel] !== 1'b0 && wait_cnt < 64) begin
         @(negedge clk);
         wait_cnt++;
      end
      chk({tag, "_start_seen"}, 32'(tx[sel] === 1'b0), 1);
      if (gap_exp >= 0) chk({tag, "_gap"}, wait_cnt, gap_exp);
      for (int t = 0; t <= Bit * n; t++) begin
         if (t % Bit == Half) begin
            chk($sformatf("%s_bit%0d", tag, t / Bit), 32'(tx[sel]), 32'(bits[t / Bit]));
         end
         if (t == Bit * n - 1) begin
            chk({tag, "_done_early"}, 32'(tx_done[sel]), 0);
            chk({tag, "_busy_mid"}, 32'(tx_busy[sel]), 1);
         end
         if (t == Bit * n) begin
            chk({tag, "_done"}, 32'(tx_done[sel]), 1);
            chk({tag, "_busy_end"}, 32'(tx_busy[sel]), 0);
            chk({tag, "_ready_end"}, 32'(tx_ready[sel]), 1);
         end
         if (t < Bit * n) @(negedge clk);
      end
   endtask

   initial begin
      int lows;
      int dones;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'h7);
      chk("rst_ready", 32'(tx_ready), 32'h7);
      chk("rst_busy", 32'(tx_busy), 0);
      chk("rst_done", 32'(tx_done), 0);
      arst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 8N1 0xA5 with handshake on a tick: the tick is not consumed, start waits a full period
      sync_tick();
      send(0, 8'hA5);
      check_frame(0, "8n1_a5", 16'h034A, 10, Bit);

      // Even parity with two stop bits, odd parity with one
      send(1, 8'hA5);
      check_frame(1, "8e2_a5", 16'h0D4A, 12, -1);
      send(2, 8'hA5);
      check_frame(2, "8o1_a5", 16'h074A, 11, -1);

      // tx_valid held: 0x00 then 0xFF back to back, one idle bit period between frames
      tx_data     = 8'h00;
      tx_valid[0] = 1'b1;
      @(negedge clk);
      chk("b2b_hs", 32'(tx_busy[0]), 1);
      tx_data = 8'hFF;
      check_frame(0, "b2b_00", 16'h0200, 10, -1);
      check_frame(0, "b2b_ff", 16'h03FE, 10, Bit);
      tx_valid[0] = 1'b0;
      @(negedge clk);
      chk("b2b_idle_busy", 32'(tx_busy[0]), 0);

      // tx_valid with 0x3C while busy is ignored
      sync_tick();
      send(0, 8'hA5);
      repeat (2) @(negedge clk);
      tx_data     = 8'h3C;
      tx_valid[0] = 1'b1;
      @(negedge clk);
      chk("busy_ready", 32'(tx_ready[0]), 0);
      @(negedge clk);
      tx_valid[0] = 1'b0;
      check_frame(0, "busy_a5", 16'h034A, 10, -1);
      lows = 0;
      for (int i = 0; i < 3 * Bit; i++) begin
         @(negedge clk);
         if (tx[0] !== 1'b1 || tx_busy[0] !== 1'b0) lows++;
      end
      chk("busy_no_3c", lows, 0);

      // Reset during data bit 3, then a clean 0x55 frame
      send(0, 8'hA5);
      lows = 0;
      while (tx[0] !== 1'b0 && lows < 64) begin
         @(negedge clk);
         lows++;
      end
      repeat (4 * Bit + Half) @(negedge clk);
      chk("mid_bit3_low", 32'(tx[0]), 0);
      #2 arst_n = 1'b0;
      #1;
      chk("mid_rst_tx", 32'(tx[0]), 1);
      chk("mid_rst_ready", 32'(tx_ready[0]), 1);
      chk("mid_rst_busy", 32'(tx_busy[0]), 0);
      dones = 0;
      for (int i = 0; i < 2 * Bit; i++) begin
         @(negedge clk);
         if (tx_done[0] !== 1'b0 || tx[0] !== 1'b1) dones++;
      end
      chk("mid_rst_quiet", dones, 0);
      arst_n = 1'b1;
      repeat (3) @(negedge clk);
      send(0, 8'h55);
      check_frame(0, "rst_55", 16'h02AA, 10, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
